// File: rtl/seq_checker.sv
// seq_checker: in-line checker for the x[n] = x[n-2] + x[n-3] sequence stream.
// Regenerates the expected term from the last accepted good terms, pulses match
// on each correct term, latches the first mismatch, and flags modulo wrap.
module seq_checker #(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED0 = '0,
    parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED2 = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             match,
    output logic             err,
    output logic [CNT_W-1:0] err_index,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_actual,
    output logic [CNT_W-1:0] term_count,
    output logic             wrapped,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, TRACK = 2'd2, FAIL = 2'd3} state_t;

    state_t           state;
    logic [WIDTH-1:0] h1, h2, h3;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             hit;
    logic             cnt_max;

    // One extra bit keeps the carry so wrap can be reported separately.
    assign sum     = {1'b0, h2} + {1'b0, h3};
    assign accept  = in_valid && (state != FAIL);
    assign hit     = (in_data == expected);
    assign cnt_max = (term_count == {CNT_W{1'b1}});
    assign state_o = state;

    // Expected term: seeds while the history is filling, recurrence afterwards.
    always_comb begin
        expected = sum[WIDTH-1:0];
        case (state)
            IDLE:    expected = SEED0;
            SEED:    expected = (term_count == CNT_W'(1)) ? SEED1 : SEED2;
            default: expected = sum[WIDTH-1:0];
        endcase
    end

    // Checker FSM, history shift, counters and error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            h1           <= '0;
            h2           <= '0;
            h3           <= '0;
            match        <= 1'b0;
            err          <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            term_count   <= '0;
            wrapped      <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            h1           <= '0;
            h2           <= '0;
            h3           <= '0;
            match        <= 1'b0;
            err          <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            term_count   <= '0;
            wrapped      <= 1'b0;
        end else begin
            match <= 1'b0;
            if (accept) begin
                if (!cnt_max)
                    term_count <= term_count + CNT_W'(1);
                if (state == TRACK && sum[WIDTH])
                    wrapped <= 1'b1;
                if (hit) begin
                    match <= 1'b1;
                    h1    <= in_data;
                    h2    <= h1;
                    h3    <= h2;
                    case (state)
                        IDLE:    state <= SEED;
                        SEED:    state <= (term_count == CNT_W'(2)) ? TRACK : SEED;
                        default: state <= state;
                    endcase
                end else begin
                    // term_count is already saturated, so err_index saturates too.
                    err          <= 1'b1;
                    err_index    <= term_count;
                    err_expected <= expected;
                    err_actual   <= in_data;
                    state        <= FAIL;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: drives a 32-bit checker and an 8-bit/5-bit-counter checker
// side by side, comparing both against a model built on the ideal sequence.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [31:0] d0;
    logic [7:0]  d1;

    logic        match0, err0, wrapped0;
    logic [15:0] err_index0, term_count0;
    logic [31:0] err_expected0, err_actual0;
    logic [1:0]  state0;

    logic        match1, err1, wrapped1;
    logic [4:0]  err_index1, term_count1;
    logic [7:0]  err_expected1, err_actual1;
    logic [1:0]  state1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_checker dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(d0),
        .match(match0), .err(err0), .err_index(err_index0),
        .err_expected(err_expected0), .err_actual(err_actual0),
        .term_count(term_count0), .wrapped(wrapped0), .state_o(state0)
    );

    seq_checker #(.WIDTH(8), .CNT_W(5)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(d1),
        .match(match1), .err(err1), .err_index(err_index1),
        .err_expected(err_expected1), .err_actual(err_actual1),
        .term_count(term_count1), .wrapped(wrapped1), .state_o(state1)
    );

    // Ideal sequence modulo 2^32; the 8-bit view is its low byte.
    logic [31:0] seq [512];

    // Model: per DUT, true index of next term, saturated count, outcome fields.
    bit          m_match [2];
    bit          m_err   [2];
    bit          m_wrap  [2];
    int          m_n     [2];
    int          m_cnt   [2];
    int          m_idx   [2];
    int          m_state [2];
    logic [31:0] m_exp   [2];
    logic [31:0] m_act   [2];

    task automatic mreset(input int id);
        m_match[id] = 0; m_err[id] = 0; m_wrap[id] = 0;
        m_n[id] = 0; m_cnt[id] = 0; m_idx[id] = 0; m_state[id] = 0;
        m_exp[id] = 0; m_act[id] = 0;
    endtask

    task automatic mdl(input int id, input bit v, input bit c, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] e;
        logic [32:0] s;
        int          n;
        int          cmax;
        mask = (id == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        cmax = (id == 0) ? 65535 : 31;
        m_match[id] = 0;
        if (c) begin
            mreset(id);
        end else if (v && m_state[id] != 3) begin
            n = m_n[id];
            e = seq[n] & mask;
            if (n >= 3) begin
                s = {1'b0, seq[n-2] & mask} + {1'b0, seq[n-3] & mask};
                if (s > {1'b0, mask}) m_wrap[id] = 1;
            end
            if ((d & mask) == e) begin
                m_match[id] = 1;
                m_state[id] = (n >= 2) ? 2 : 1;
            end else begin
                m_err[id] = 1; m_idx[id] = m_cnt[id];
                m_exp[id] = e; m_act[id] = d & mask; m_state[id] = 3;
            end
            m_n[id] = n + 1;
            if (m_cnt[id] < cmax) m_cnt[id] = m_cnt[id] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d32.match",    {31'b0, match0},   {31'b0, m_match[0]});
        chk("d32.err",      {31'b0, err0},     {31'b0, m_err[0]});
        chk("d32.err_index", {16'b0, err_index0}, m_idx[0]);
        chk("d32.err_expected", err_expected0, m_exp[0]);
        chk("d32.err_actual",   err_actual0,   m_act[0]);
        chk("d32.term_count", {16'b0, term_count0}, m_cnt[0]);
        chk("d32.wrapped",  {31'b0, wrapped0}, {31'b0, m_wrap[0]});
        chk("d32.state",    {30'b0, state0},   m_state[0]);
        chk("d8.match",     {31'b0, match1},   {31'b0, m_match[1]});
        chk("d8.err",       {31'b0, err1},     {31'b0, m_err[1]});
        chk("d8.err_index", {27'b0, err_index1}, m_idx[1]);
        chk("d8.err_expected", {24'b0, err_expected1}, m_exp[1]);
        chk("d8.err_actual",   {24'b0, err_actual1},   m_act[1]);
        chk("d8.term_count", {27'b0, term_count1}, m_cnt[1]);
        chk("d8.wrapped",   {31'b0, wrapped1}, {31'b0, m_wrap[1]});
        chk("d8.state",     {30'b0, state1},   m_state[1]);
    endtask

    // One clock: each DUT gets its own next ideal term XOR an error mask.
    task automatic step(input bit v, input bit c, input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] x0, x1;
        x0 = seq[m_n[0]] ^ e0;
        x1 = (seq[m_n[1]] ^ e1) & 32'hFF;
        in_valid = v; clear = c; d0 = x0; d1 = x1[7:0];
        @(posedge clk);
        mdl(0, v, c, x0);
        mdl(1, v, c, x1);
        #1;
        check_all();
    endtask

    initial begin
        seq[0] = 0; seq[1] = 1; seq[2] = 1;
        for (int i = 3; i < 512; i++) seq[i] = seq[i-2] + seq[i-3];
        mreset(0); mreset(1);

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; d0 = '0; d1 = '0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Sixteen correct terms back to back.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        chk("plan.count16", {16'b0, term_count0}, 32'd16);

        // Wrong value 10 at index 10, then five more terms that must be ignored.
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        step(1, 0, 32'd3, 32'd3);
        chk("plan.err_actual10", err_actual0, 32'd10);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

        // Clear out of FAIL, then a short restart.
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Same stream with in_valid pattern 1,0,0.
        step(0, 1, 0, 0);
        for (int i = 0; i < 48; i++) step((i % 3) == 0, 0, 0, 0);

        // clear together with a valid term: the term is dropped.
        step(1, 1, 0, 0);

        // Long correct run: 8-bit wrap at index 22, 5-bit count saturation,
        // and 32-bit wrap near index 80.
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0);

        // Async reset mid-TRACK at term_count 7, then a bad first term.
        step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        rst = 1'b0;
        #2;
        mreset(0); mreset(1);
        check_all();
        rst = 1'b1;
        step(1, 0, 32'd5, 32'd5);

        // Random traffic: sparse clears and sparse injected errors.
        step(0, 1, 0, 0);
        for (int i = 0; i < 250; i++) begin
            bit v, c;
            logic [31:0] e0, e1;
            v  = ($urandom % 4) != 0;
            c  = ($urandom % 100) == 0;
            e0 = (($urandom % 100) == 0) ? (32'h1 << ($urandom % 32)) : 32'h0;
            e1 = (($urandom % 100) == 0) ? (32'h1 << ($urandom % 8))  : 32'h0;
            if (m_n[0] > 400 || m_n[1] > 400) c = 1;
            step(v, c, e0, e1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Stream checker that sits directly downstream of the 32-bit special sequence generator. The generator's recurrence is x[n] = x[n-2] + x[n-3], seeded 0, 1, 1.
- Consumes one term per valid cycle and verifies each term against an internally regenerated expected value.
- Reports per-term match pulses, a sticky first-error capture, a term count and sticky arithmetic wrap detection.
- Used as an in-system self-check and as a bench scoreboard for the generator.

Parameters:
- WIDTH, 32, data width of checked terms.
- CNT_W, 16, width of term counter and error index.
- SEED0, 0, expected term 0.
- SEED1, 1, expected term 1.
- SEED2, 1, expected term 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart; same effect as reset.
- in_valid  input  1  in_data holds a term this cycle.
- in_data  input  WIDTH  sequence term under test.
- match  output  1  one-cycle pulse: the term accepted last cycle was correct.
- err  output  1  sticky: mismatch detected.
- err_index  output  CNT_W  index of the first mismatching term.
- err_expected  output  WIDTH  expected value at the first mismatch.
- err_actual  output  WIDTH  received value at the first mismatch.
- term_count  output  CNT_W  number of terms accepted and checked.
- wrapped  output  1  sticky: an expected-value sum carried out of WIDTH bits.
- state_o  output  2  current state: 0=IDLE, 1=SEED, 2=TRACK, 3=FAIL.

Behaviour:
- Reset is clk, asynchronous, active-low (rst). On rst low, all outputs and internal registers go to 0 and state goes to IDLE.
- clear is synchronous and has priority over all other activity in that cycle. Its effect is identical to reset.
- A term is accepted on a rising edge with in_valid=1 while state is not FAIL. in_valid=0 cycles are ignored: no state change, and history holds.
- Internal history: h1, h2, h3 hold the terms received 1, 2 and 3 acceptances ago. The history shifts only on accepted terms that match.
- Expected value:
  - Index 0..2: SEED0..SEED2.
  - Index >= 3: the sum (h2 + h3) is computed in WIDTH+1 bits. The compare uses the low WIDTH bits, matching the generator's modulo-2^WIDTH wrap.
- A carry out of that sum on an accepted term sets wrapped. wrapped stays set until reset or clear. Wrap is not an error.
- FSM:
  - IDLE: the first accepted term is compared to SEED0. Go to SEED.
  - SEED: terms at index 1 and 2 are compared to SEED1 and SEED2. Go to TRACK after index 2 is accepted.
  - TRACK: terms are compared to h2 + h3.
  - Any mismatch, from any state: go to FAIL.
  - FAIL: absorbing. Inputs are ignored; term_count, the err_* fields and history freeze. Exit only by rst or clear.
- Latency: all outputs are registered and update one clock after the accepting edge.
  - On a correct term: match=1 for exactly one cycle, and term_count increments.
  - On a mismatch: match stays 0 and err goes to 1. err_index receives the term's index, which equals the term_count value before the increment. err_expected and err_actual are captured. term_count still increments, counting the failing term.
- term_count saturates at 2^CNT_W - 1. Checking continues after saturation. err_index saturates the same way.
- clear asserted in the same cycle as in_valid: clear wins, and the term is dropped.
- rst asserted mid-stream: immediate return to IDLE with zeroed outputs. The next accepted term is treated as index 0.

Test Plan:
- Reset, then feed 16 correct terms back-to-back: 0,1,1,1,2,2,3,4,5,7,9,12,16,21,28,37 -> 16 match pulses, term_count=16, err=0, wrapped=0, state_o=2.
- Feed a correct stream but send 10 at index 10 (expected 9) -> err=1, err_index=10, err_expected=9, err_actual=10, term_count=11, state_o=3. Send 5 further terms -> no change.
- Same 16-term stream with in_valid toggling 1,0,0,1,... -> identical results to the back-to-back case; no match pulse on idle cycles.
- WIDTH=8: feed terms to index 22, with index 21=200 and index 22=9 (265 mod 256) -> match at 22, wrapped=1, err=0, term_count=23.
- After FAIL, pulse clear for one cycle, then feed 0,1,1,1 -> err=0, term_count=4, 4 match pulses, state_o=2.
- Drive rst low asynchronously between clock edges mid-TRACK (term_count=7) -> outputs 0 and state_o=0 immediately, without waiting for a clock edge. After release, a first term of 5 -> err=1, err_index=0, err_expected=0, err_actual=5.
